// File: rtl/pwm_bank_if.sv
// pwm_bank_if: register write port of the PWM bank.
// The SPI register front-end drives it as master; pwm_bank consumes it as slave.
interface pwm_bank_if;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator.
// - It has a shared prescaler and a shared period counter.
// - Each channel has its own duty register.
// - Register writes arrive through pwm_bank_if.
// Build option PWM_SHADOW_EN:
// - Defined: DUTY/PERIOD writes land in staging registers. They are copied to
//   the active copies only when the counter wraps, so a running period is never
//   truncated.
// - Undefined: writes go straight to the active values.
module pwm_bank #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8,
    parameter int PS_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_bank_if.slave           wr,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam logic [4:0] ADDR_OUT_EN   = 5'h00;
    localparam logic [4:0] ADDR_PWM_EN   = 5'h01;
    localparam logic [4:0] ADDR_PRESCALE = 5'h02;
    localparam logic [4:0] ADDR_PERIOD   = 5'h03;
    localparam logic [4:0] ADDR_DUTY0    = 5'h10;

    // Write decode
    logic             wr_out_en;
    logic             wr_pwm_en;
    logic             wr_prescale;
    logic             wr_period;
    logic [CNT_W-1:0] wr_val;
    logic             wr_data_unused;

    assign wr_out_en   = wr.wr_en && (wr.wr_addr == ADDR_OUT_EN);
    assign wr_pwm_en   = wr.wr_en && (wr.wr_addr == ADDR_PWM_EN);
    assign wr_prescale = wr.wr_en && (wr.wr_addr == ADDR_PRESCALE);
    assign wr_period   = wr.wr_en && (wr.wr_addr == ADDR_PERIOD);
    assign wr_val      = wr.wr_data[CNT_W-1:0];
    // The upper data bits are don't-care for every register.
    assign wr_data_unused = &{1'b0, wr.wr_data};

    // Control registers
    logic [CHANNELS-1:0] out_en_q;
    logic [CHANNELS-1:0] pwm_en_q;
    logic [PS_W-1:0]     prescale_q;
    logic [CNT_W-1:0]    period_q;

    // Control registers update on the edge that accepts the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_q   <= '0;
            pwm_en_q   <= '0;
            prescale_q <= '0;
            period_q   <= '1;
        end else begin
            if (wr_out_en)   out_en_q   <= wr.wr_data[CHANNELS-1:0];
            if (wr_pwm_en)   pwm_en_q   <= wr.wr_data[CHANNELS-1:0];
            if (wr_prescale) prescale_q <= wr.wr_data[PS_W-1:0];
            if (wr_period)   period_q   <= wr_val;
        end
    end

    // Counters
    logic [PS_W-1:0]  ps_cnt_q;
    logic [PS_W-1:0]  ps_cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_act;
    logic             tick;
    logic             wrap;
    logic             wrap_q;

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] period_act_q;

    // Active period reloads only at a wrap.
    // A PERIOD write landing on that same edge bypasses the staging register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act_q <= '1;
        end else if (wrap) begin
            period_act_q <= wr_period ? wr_val : period_q;
        end
    end
    assign period_act = period_act_q;
`else
    assign period_act = period_q;
`endif

    // Prescaler tick, wrap detection and next counter values.
    // The >= compares make a lowered PRESCALE/PERIOD take effect at once
    // instead of waiting for the counters to roll over.
    always_comb begin
        tick     = (ps_cnt_q >= prescale_q);
        wrap     = tick && (cnt_q >= period_act);
        ps_cnt_d = tick ? '0 : ps_cnt_q + PS_W'(1);
        cnt_d    = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state. wrap_q remembers that cnt has just returned to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap;
        end
    end

    // Per-channel duty registers and comparators
    logic [CHANNELS-1:0] lvl;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic             wr_duty;
            logic [CNT_W-1:0] duty_q;
            logic [CNT_W-1:0] duty_act;

            assign wr_duty = wr.wr_en && (wr.wr_addr == ADDR_DUTY0 + 5'(gi));

            // Duty register for this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_q <= '0;
                end else if (wr_duty) begin
                    duty_q <= wr_val;
                end
            end

`ifdef PWM_SHADOW_EN
            logic [CNT_W-1:0] duty_act_q;

            // Active duty reloads at a wrap.
            // A same-edge write bypasses the staging register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_act_q <= '0;
                end else if (wrap) begin
                    duty_act_q <= wr_duty ? wr_val : duty_q;
                end
            end
            assign duty_act = duty_act_q;
`else
            assign duty_act = duty_q;
`endif

            // The unsigned compare covers two edge cases: DUTY=0 is never
            // high, and DUTY>PERIOD is always high.
            assign lvl[gi] = (cnt_q < duty_act);
        end
    endgenerate

    // Outputs
    logic [CHANNELS-1:0] pwm_d;
    logic [CHANNELS-1:0] pwm_out_q;
    logic                period_start_q;

    // A channel with PWM disabled but output enabled is driven constantly high.
    assign pwm_d = out_en_q & ((pwm_en_q & lvl) | ~pwm_en_q);

    // pwm_out shows the level of the previous cycle's count.
    // period_start is taken from wrap_q, not wrap, so that it pulses in the
    // same cycle that pwm_out shows the cnt=0 levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pwm_out_q      <= pwm_d;
            period_start_q <= wrap_q;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
endmodule
